ldpc_3gpp_enc_mm_acc: RTL and testbench

LDPC_3GPP_ENC_MM_ACC -- requirements
Module: ldpc_3gpp_enc_mm_acc

---
 rtl/ldpc_3gpp_enc_mm_acc.sv | 133 +++++++++++++
 tb/tb_ldpc_3gpp_enc_mm_acc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ldpc_3gpp_enc_mm_acc.sv
// GF(2) row accumulator for the LDPC encoder: XORs the shifted Zc blocks of one Hb row word-wise
// and streams the row sum out during the last block, one cycle after each input word.
module ldpc_3gpp_enc_mm_acc #(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              iclkena,
    input  logic              ival,
    input  logic              isop,
    input  logic              ieop,
    input  logic              isof,
    input  logic              ieof,
    input  logic [pDAT_W-1:0] idat,
    output logic              oval,
    output logic              osop,
    output logic              oeop,
    output logic [pDAT_W-1:0] odat,
    output logic              oerr
);

    typedef enum logic [1:0] {
        sIDLE = 2'd0,
        sACC  = 2'd1,
        sLAST = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [pDAT_W-1:0]   r_buf [2**pADDR_W];
    logic [pADDR_W-1:0]  r_waddr;
    logic [pADDR_W-1:0]  w_addr;
    logic                r_first;
    logic                w_acc;
    logic                w_ok;
    logic                w_frm_err;
    logic                w_wrap_err;
    logic                w_first;
    logic                w_last;
    logic [pDAT_W-1:0]   w_rd;
    logic [pDAT_W-1:0]   w_sum;
    logic                r_oval;
    logic                r_osop;
    logic                r_oeop;
    logic [pDAT_W-1:0]   r_odat;
    logic                r_oerr;

    assign w_acc      = iclkena & ival;
    assign w_addr     = isop ? '0 : r_waddr;
    assign w_wrap_err = (w_addr == '1) & ~ieop;
    assign w_rd       = r_buf[w_addr];
    assign w_sum      = w_first ? idat : (w_rd ^ idat);

    // A block boundary (isop) redefines the first/last-block context; mid-block words inherit it.
    always_comb begin
        w_ok        = 1'b0;
        w_frm_err   = 1'b0;
        w_first     = isop ? isof : r_first;
        w_last      = isop ? ieof : (r_state == sLAST);
        w_state_nxt = r_state;
        case (r_state)
            sIDLE: begin
                w_ok      = isop & isof;
                w_frm_err = ~(isop & isof);
            end
            sACC: begin
                w_ok      = 1'b1;
                w_frm_err = isop & isof;
            end
            sLAST: begin
                w_ok      = ~isop | isof;
                w_frm_err = isop;
            end
            default: begin
                w_ok      = 1'b0;
                w_frm_err = 1'b1;
            end
        endcase
        if (w_acc) begin
            if (!w_ok)
                w_state_nxt = sIDLE;
            else if (w_last)
                w_state_nxt = ieop ? sIDLE : sLAST;
            else
                w_state_nxt = sACC;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_state <= sIDLE;
            r_waddr <= '0;
            r_first <= 1'b0;
            r_oval  <= 1'b0;
            r_osop  <= 1'b0;
            r_oeop  <= 1'b0;
            r_odat  <= '0;
            r_oerr  <= 1'b0;
        end else if (iclkena) begin
            r_state <= w_state_nxt;
            r_oval  <= 1'b0;
            r_osop  <= 1'b0;
            r_oeop  <= 1'b0;
            if (ival) begin
                r_waddr <= w_addr + pADDR_W'(1);
                if (isop)
                    r_first <= isof;
                if (w_frm_err || w_wrap_err)
                    r_oerr <= 1'b1;
                if (w_ok && w_last) begin
                    r_oval <= 1'b1;
                    r_osop <= isop;
                    r_oeop <= ieop;
                    r_odat <= w_sum;
                end
            end
        end
    end

    // Accumulator storage is deliberately left out of reset; every row overwrites it in its first block.
    always_ff @(posedge iclk) begin
        if (w_acc && w_ok)
            r_buf[w_addr] <= w_sum;
    end

    assign oval = r_oval;
    assign osop = r_osop;
    assign oeop = r_oeop;
    assign odat = r_odat;
    assign oerr = r_oerr;

endmodule

// File: tb/tb_ldpc_3gpp_enc_mm_acc.sv
// Directed bench for the row accumulator: 4-word blocks, golden per-word XOR model feeding an output scoreboard.
module tb_ldpc_3gpp_enc_mm_acc;

    logic       iclk = 1'b0;
    logic       ireset_n;
    logic       iclkena;
    logic       ival, isop, ieop, isof, ieof;
    logic [7:0] idat;
    logic       oval, osop, oeop, oerr;
    logic [7:0] odat;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q [$];
    logic [9:0] mon_e;
    logic       mon_ena;
    logic [7:0] rowd [0:3][0:3];
    int         stall_c = -1;
    int         stall_w = -1;

    ldpc_3gpp_enc_mm_acc #(.pADDR_W(8), .pDAT_W(8)) dut (
        .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena), .ival(ival),
        .isop(isop), .ieop(ieop), .isof(isof), .ieof(ieof), .idat(idat),
        .oval(oval), .osop(osop), .oeop(oeop), .odat(odat), .oerr(oerr)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs only advance on enabled edges, so held values during a stall are not new words.
    always @(posedge iclk) begin
        mon_ena = iclkena;
        #1;
        if (mon_ena && oval) begin
            if (exp_q.size() == 0)
                chk("extra_oval", 32'd1, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("odat", {24'd0, odat}, {24'd0, mon_e[7:0]});
                chk("osop", {31'd0, osop}, {31'd0, mon_e[9]});
                chk("oeop", {31'd0, oeop}, {31'd0, mon_e[8]});
            end
        end
    end

    task automatic drive(input logic v, input logic sop, input logic eop,
                         input logic sof, input logic eof, input logic [7:0] d);
        @(negedge iclk);
        iclkena = 1'b1;
        ival = v; isop = sop; ieop = eop; isof = sof; ieof = eof; idat = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic stall5();
        for (int i = 0; i < 5; i++) begin
            @(negedge iclk);
            iclkena = 1'b0;
            ival = 1'($urandom); isop = 1'($urandom); ieop = 1'($urandom);
            isof = 1'($urandom); ieof = 1'($urandom); idat = 8'($urandom);
        end
    endtask

    task automatic send_block(input int c, input int ncols, input bit gaps);
        logic [7:0] e;
        if (c == ncols - 1) begin
            for (int w = 0; w < 4; w++) begin
                e = 8'h00;
                for (int k = 0; k < ncols; k++) e = e ^ rowd[k][w];
                exp_q.push_back({w == 0, w == 3, e});
            end
        end
        for (int w = 0; w < 4; w++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) idle(1);
            if (c == stall_c && w == stall_w) stall5();
            drive(1'b1, w == 0, w == 3, (c == 0) && (w == 0), (c == ncols - 1) && (w == 0), rowd[c][w]);
        end
    endtask

    task automatic send_row(input int ncols, input bit gaps);
        for (int c = 0; c < ncols; c++) send_block(c, ncols, gaps);
    endtask

    task automatic rand_row(input int ncols);
        for (int c = 0; c < ncols; c++)
            for (int w = 0; w < 4; w++) rowd[c][w] = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge iclk);
        chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        ireset_n = 1'b0; iclkena = 1'b1;
        ival = 1'b0; isop = 1'b0; ieop = 1'b0; isof = 1'b0; ieof = 1'b0; idat = 8'h00;
        repeat (3) @(negedge iclk);
        chk("rst_oval", {31'd0, oval}, 32'd0);
        chk("rst_osop", {31'd0, osop}, 32'd0);
        chk("rst_oeop", {31'd0, oeop}, 32'd0);
        chk("rst_odat", {24'd0, odat}, 32'd0);
        chk("rst_oerr", {31'd0, oerr}, 32'd0);
        ireset_n = 1'b1;
        idle(2);

        // single-column row: output equals input, one cycle later
        rowd[0][0] = 8'h11; rowd[0][1] = 8'h22; rowd[0][2] = 8'h33; rowd[0][3] = 8'h44;
        send_row(1, 1'b0);
        idle(4);
        drain();
        chk("hold_oval", {31'd0, oval}, 32'd0);
        chk("hold_odat", {24'd0, odat}, 32'h44);
        chk("hold_oeop", {31'd0, oeop}, 32'd0);

        // three-column row that cancels to zero
        for (int w = 0; w < 4; w++) begin
            rowd[0][w] = 8'h0F; rowd[1][w] = 8'hF0; rowd[2][w] = 8'hFF;
        end
        send_row(3, 1'b0);
        idle(3);
        drain();

        // back-to-back rows with random widths, data and ival gaps
        for (int r = 0; r < 6; r++) begin
            int nc;
            nc = $urandom_range(1, 4);
            rand_row(nc);
            send_row(nc, 1'b1);
        end
        idle(3);
        drain();

        // clock-enable stall mid-block with garbage on the inputs
        rand_row(3);
        stall_c = 1; stall_w = 2;
        send_row(3, 1'b0);
        stall_c = 2; stall_w = 1;
        rand_row(2);
        send_row(2, 1'b0);
        stall_c = -1; stall_w = -1;
        idle(3);
        drain();
        chk("oerr_clean", {31'd0, oerr}, 32'd0);

        // block start without isof while idle
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        idle(3);
        chk("oerr_set", {31'd0, oerr}, 32'd1);
        rand_row(2);
        send_row(2, 1'b0);
        idle(3);
        drain();
        chk("oerr_sticky", {31'd0, oerr}, 32'd1);

        // reset during block 2 of 3 aborts the row silently
        rand_row(3);
        send_block(0, 3, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rowd[1][0]);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rowd[1][1]);
        @(negedge iclk);
        ival = 1'b0;
        ireset_n = 1'b0;
        repeat (2) @(negedge iclk);
        chk("abort_oval", {31'd0, oval}, 32'd0);
        chk("abort_oerr", {31'd0, oerr}, 32'd0);
        ireset_n = 1'b1;
        idle(2);
        rand_row(2);
        send_row(2, 1'b1);
        idle(3);
        drain();
        chk("post_rst_oerr", {31'd0, oerr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
